// File: rtl/axi_lite_master_bridge.sv
// AXI4-Lite initiator: turns a single-outstanding dmem-style request into AXI4-Lite transactions.
// Optional debug watchdog enabled by defining AXI_MASTER_TIMEOUT_EN.
module axi_lite_master_bridge #(
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [ADDR_WIDTH-1:0]     req_addr,
    input  logic [DATA_WIDTH-1:0]     req_wdata,
    input  logic [DATA_WIDTH/8-1:0]   req_byte_enable,
    input  logic                      req_read,
    input  logic                      req_write,
    output logic [DATA_WIDTH-1:0]     req_rdata,
    output logic                      req_ready,
    output logic                      req_error,
    output logic [ADDR_WIDTH-1:0]     m_axi_awaddr,
    output logic [2:0]                m_axi_awprot,
    output logic                      m_axi_awvalid,
    input  logic                      m_axi_awready,
    output logic [DATA_WIDTH-1:0]     m_axi_wdata,
    output logic [DATA_WIDTH/8-1:0]   m_axi_wstrb,
    output logic                      m_axi_wvalid,
    input  logic                      m_axi_wready,
    input  logic [1:0]                m_axi_bresp,
    input  logic                      m_axi_bvalid,
    output logic                      m_axi_bready,
    output logic [ADDR_WIDTH-1:0]     m_axi_araddr,
    output logic [2:0]                m_axi_arprot,
    output logic                      m_axi_arvalid,
    input  logic                      m_axi_arready,
    input  logic [DATA_WIDTH-1:0]     m_axi_rdata,
    input  logic [1:0]                m_axi_rresp,
    input  logic                      m_axi_rvalid,
    output logic                      m_axi_rready
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_WR_REQ  = 3'd1;
    localparam logic [2:0] S_WR_RESP = 3'd2;
    localparam logic [2:0] S_RD_REQ  = 3'd3;
    localparam logic [2:0] S_RD_RESP = 3'd4;
    localparam logic [2:0] S_DONE    = 3'd5;

    logic [2:0]              state_q, state_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic [DATA_WIDTH/8-1:0] wstrb_q, wstrb_d;
    logic                    aw_done_q, aw_done_d;
    logic                    w_done_q, w_done_d;
    logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
    logic                    error_q, error_d;
    logic                    timeout_hit;
    logic                    aw_hs, w_hs, b_hs, ar_hs, r_hs;

`ifdef AXI_MASTER_TIMEOUT_EN
    logic [31:0] wait_cnt_q, wait_cnt_d;
    logic        waiting;

    assign waiting = (state_q == S_WR_REQ) || (state_q == S_WR_RESP) ||
                     (state_q == S_RD_REQ) || (state_q == S_RD_RESP);
    // Fires in the cycle whose increment would make the count reach the limit.
    assign timeout_hit = waiting && (wait_cnt_q == 32'(TIMEOUT_CYCLES - 1));

    always_comb begin
        wait_cnt_d = wait_cnt_q;
        if (state_q == S_IDLE) begin
            wait_cnt_d = '0;
        end else if (waiting) begin
            wait_cnt_d = wait_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt_q <= '0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
        end
    end
`else
    // Watchdog limit has no effect in this build.
    localparam int unsigned unused_timeout_cycles = TIMEOUT_CYCLES;
    assign timeout_hit = 1'b0;
`endif

    assign m_axi_awvalid = (state_q == S_WR_REQ) && !aw_done_q && !timeout_hit;
    assign m_axi_wvalid  = (state_q == S_WR_REQ) && !w_done_q && !timeout_hit;
    assign m_axi_bready  = (state_q == S_WR_RESP) && !timeout_hit;
    assign m_axi_arvalid = (state_q == S_RD_REQ) && !timeout_hit;
    assign m_axi_rready  = (state_q == S_RD_RESP) && !timeout_hit;
    assign req_ready     = (state_q == S_DONE);

    assign aw_hs = m_axi_awvalid && m_axi_awready;
    assign w_hs  = m_axi_wvalid && m_axi_wready;
    assign b_hs  = m_axi_bvalid && m_axi_bready;
    assign ar_hs = m_axi_arvalid && m_axi_arready;
    assign r_hs  = m_axi_rvalid && m_axi_rready;

    assign m_axi_awaddr = addr_q;
    assign m_axi_araddr = addr_q;
    assign m_axi_awprot = 3'b000;
    assign m_axi_arprot = 3'b000;
    assign m_axi_wdata  = wdata_q;
    assign m_axi_wstrb  = wstrb_q;
    assign req_rdata    = rdata_q;
    assign req_error    = error_q;

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        rdata_d   = rdata_q;
        error_d   = error_q;
        case (state_q)
            S_IDLE: begin
                if (req_write) begin
                    addr_d    = req_addr;
                    wdata_d   = req_wdata;
                    wstrb_d   = req_byte_enable;
                    error_d   = 1'b0;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    state_d   = S_WR_REQ;
                end else if (req_read) begin
                    addr_d  = req_addr;
                    error_d = 1'b0;
                    state_d = S_RD_REQ;
                end
            end
            S_WR_REQ: begin
                // Same-cycle handshakes count towards leaving this state.
                aw_done_d = aw_done_q || aw_hs;
                w_done_d  = w_done_q || w_hs;
                if (aw_done_d && w_done_d) begin
                    state_d = S_WR_RESP;
                end
            end
            S_WR_RESP: begin
                if (b_hs) begin
                    error_d = (m_axi_bresp != 2'b00);
                    state_d = S_DONE;
                end
            end
            S_RD_REQ: begin
                if (ar_hs) begin
                    state_d = S_RD_RESP;
                end
            end
            S_RD_RESP: begin
                if (r_hs) begin
                    rdata_d = m_axi_rdata;
                    error_d = (m_axi_rresp != 2'b00);
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (timeout_hit) begin
            state_d = S_DONE;
            error_d = 1'b1;
            if ((state_q == S_RD_REQ) || (state_q == S_RD_RESP)) begin
                rdata_d = DATA_WIDTH'(32'hDEADBEEF);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            addr_q    <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            rdata_q   <= '0;
            error_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
            rdata_q   <= rdata_d;
            error_q   <= error_d;
        end
    end

endmodule

// File: tb/tb_axi_lite_master_bridge.sv
// Self-checking bench for axi_lite_master_bridge: directed vector table, reset/watchdog sequences,
// and randomized transactions against a latency/result model of the bridge.
module tb_axi_lite_master_bridge;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] req_addr, req_wdata, req_rdata;
    logic [3:0]  req_byte_enable;
    logic        req_read, req_write, req_ready, req_error;
    logic [31:0] m_axi_awaddr, m_axi_wdata, m_axi_araddr, m_axi_rdata;
    logic [2:0]  m_axi_awprot, m_axi_arprot;
    logic [3:0]  m_axi_wstrb;
    logic        m_axi_awvalid, m_axi_awready, m_axi_wvalid, m_axi_wready;
    logic        m_axi_bvalid, m_axi_bready, m_axi_arvalid, m_axi_arready;
    logic        m_axi_rvalid, m_axi_rready;
    logic [1:0]  m_axi_bresp, m_axi_rresp;

    always #5 clk = ~clk;

    axi_lite_master_bridge #(
        .ADDR_WIDTH(32),
        .DATA_WIDTH(32),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .clk(clk), .rst(rst),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_byte_enable(req_byte_enable),
        .req_read(req_read), .req_write(req_write),
        .req_rdata(req_rdata), .req_ready(req_ready), .req_error(req_error),
        .m_axi_awaddr(m_axi_awaddr), .m_axi_awprot(m_axi_awprot),
        .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
        .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb),
        .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
        .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready),
        .m_axi_araddr(m_axi_araddr), .m_axi_arprot(m_axi_arprot),
        .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
        .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
        .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready)
    );

    // Slave responder configuration (per transaction).
    int unsigned cfg_aw_dly, cfg_w_dly, cfg_ar_dly, cfg_rsp_dly;
    logic [1:0]  cfg_resp;
    logic [31:0] cfg_rdata;

    int unsigned aw_cnt, w_cnt, ar_cnt, b_cnt, r_cnt;
    logic        aw_got, w_got, b_pend, r_pend;
    logic [31:0] seen_awaddr, seen_wdata, seen_araddr;
    logic [3:0]  seen_wstrb;
    int unsigned cyc, aw_cyc, w_cyc, ar_cyc, aw_count, ar_count, ready_pulses, proto_errs;
    logic        prev_aw_wait, prev_w_wait, prev_ar_wait;
    bit          mon_en = 1'b1;

    assign m_axi_awready = m_axi_awvalid && (aw_cnt >= cfg_aw_dly);
    assign m_axi_wready  = m_axi_wvalid && (w_cnt >= cfg_w_dly);
    assign m_axi_arready = m_axi_arvalid && (ar_cnt >= cfg_ar_dly);
    assign m_axi_bvalid  = b_pend && (b_cnt >= cfg_rsp_dly);
    assign m_axi_rvalid  = r_pend && (r_cnt >= cfg_rsp_dly);
    assign m_axi_bresp   = m_axi_bvalid ? cfg_resp : 2'b11;
    assign m_axi_rresp   = m_axi_rvalid ? cfg_resp : 2'b11;
    assign m_axi_rdata   = m_axi_rvalid ? cfg_rdata : ~cfg_rdata;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (req_ready) ready_pulses <= ready_pulses + 1;
        prev_aw_wait <= !rst && m_axi_awvalid && !m_axi_awready;
        prev_w_wait  <= !rst && m_axi_wvalid && !m_axi_wready;
        prev_ar_wait <= !rst && m_axi_arvalid && !m_axi_arready;
        if (!rst && mon_en) begin
            if ((prev_aw_wait && !m_axi_awvalid) || (prev_w_wait && !m_axi_wvalid) ||
                (prev_ar_wait && !m_axi_arvalid) || (m_axi_bready && !b_pend) ||
                (m_axi_rready && !r_pend) || (m_axi_awprot != 3'b000) || (m_axi_arprot != 3'b000))
                proto_errs <= proto_errs + 1;
        end
        if (rst) begin
            aw_cnt <= 0; w_cnt <= 0; ar_cnt <= 0; b_cnt <= 0; r_cnt <= 0;
            aw_got <= 1'b0; w_got <= 1'b0; b_pend <= 1'b0; r_pend <= 1'b0;
        end else begin
            aw_cnt <= (m_axi_awvalid && !m_axi_awready) ? aw_cnt + 1 : 0;
            w_cnt  <= (m_axi_wvalid && !m_axi_wready) ? w_cnt + 1 : 0;
            ar_cnt <= (m_axi_arvalid && !m_axi_arready) ? ar_cnt + 1 : 0;
            if (m_axi_awvalid && m_axi_awready) begin
                seen_awaddr <= m_axi_awaddr; aw_cyc <= cyc; aw_got <= 1'b1; aw_count <= aw_count + 1;
            end
            if (m_axi_wvalid && m_axi_wready) begin
                seen_wdata <= m_axi_wdata; seen_wstrb <= m_axi_wstrb; w_cyc <= cyc; w_got <= 1'b1;
            end
            if ((aw_got || (m_axi_awvalid && m_axi_awready)) && (w_got || (m_axi_wvalid && m_axi_wready))) begin
                aw_got <= 1'b0; w_got <= 1'b0; b_pend <= 1'b1; b_cnt <= 0;
            end else if (b_pend && !m_axi_bvalid) begin
                b_cnt <= b_cnt + 1;
            end
            if (m_axi_bvalid && m_axi_bready) b_pend <= 1'b0;
            if (m_axi_arvalid && m_axi_arready) begin
                seen_araddr <= m_axi_araddr; ar_cyc <= cyc; ar_count <= ar_count + 1;
                r_pend <= 1'b1; r_cnt <= 0;
            end else if (r_pend && !m_axi_rvalid) begin
                r_cnt <= r_cnt + 1;
            end
            if (m_axi_rvalid && m_axi_rready) r_pend <= 1'b0;
        end
    end

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;
    logic [31:0] model_rdata;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic run_txn(input string tag, input logic wr, input logic rd,
                           input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] be,
                           input int unsigned awd, input int unsigned wd, input int unsigned ard,
                           input int unsigned rspd, input logic [1:0] resp, input logic [31:0] rdata,
                           input int unsigned exp_lat, input logic exp_err, input logic [31:0] exp_rdata);
        int unsigned start, lat, pulses0, awc0, arc0;
        @(negedge clk);
        cfg_aw_dly = awd; cfg_w_dly = wd; cfg_ar_dly = ard; cfg_rsp_dly = rspd;
        cfg_resp = resp; cfg_rdata = rdata;
        req_addr = addr; req_wdata = wdata; req_byte_enable = be;
        req_write = wr; req_read = rd;
        start = cyc; pulses0 = ready_pulses; awc0 = aw_count; arc0 = ar_count;
        lat = 0;
        for (int c = 1; c <= 200; c++) begin
            @(posedge clk); #1;
            // Inputs outside IDLE must be ignored.
            req_addr = ~addr; req_wdata = ~wdata; req_byte_enable = ~be;
            if (req_ready) begin
                lat = c;
                break;
            end
        end
        check({tag, " latency"}, 64'(lat), 64'(exp_lat));
        check({tag, " req_error"}, 64'(req_error), 64'(exp_err));
        check({tag, " req_rdata"}, 64'(req_rdata), 64'(exp_rdata));
        req_write = 1'b0; req_read = 1'b0;
        @(posedge clk); #1;
        check({tag, " ready one cycle"}, 64'(req_ready), 64'd0);
        check({tag, " ready pulses"}, 64'(ready_pulses - pulses0), 64'd1);
        if (wr) begin
            check({tag, " awaddr"}, 64'(seen_awaddr), 64'(addr));
            check({tag, " wdata"}, 64'(seen_wdata), 64'(wdata));
            check({tag, " wstrb"}, 64'(seen_wstrb), 64'(be));
            check({tag, " aw cycle"}, 64'(aw_cyc - start), 64'(1 + awd));
            check({tag, " w cycle"}, 64'(w_cyc - start), 64'(1 + wd));
            check({tag, " no read issued"}, 64'(ar_count - arc0), 64'd0);
        end else begin
            check({tag, " araddr"}, 64'(seen_araddr), 64'(addr));
            check({tag, " ar cycle"}, 64'(ar_cyc - start), 64'(1 + ard));
            check({tag, " no write issued"}, 64'(aw_count - awc0), 64'd0);
        end
    endtask

    typedef struct {
        logic        wr;
        logic        rd;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        int unsigned aw_dly;
        int unsigned w_dly;
        int unsigned ar_dly;
        int unsigned rsp_dly;
        logic [1:0]  resp;
        logic [31:0] rdata;
        int unsigned exp_lat;
        logic        exp_err;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs[8];

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation exceeded its time limit");
        $fatal(1, "bench time limit");
    end

    initial begin
        logic        wr, rd, seen, exp_err;
        logic [31:0] addr, wdata, rdata;
        logic [3:0]  be;
        logic [1:0]  resp;
        int unsigned awd, wd, ard, rspd, exp_lat, pulses0;

        vecs[0] = '{1'b1, 1'b0, 32'h0000_000C, 32'h0000_1000, 4'hF, 0, 0, 0, 0, 2'b00, 32'h0,         3, 1'b0, 32'h0000_0000};
        vecs[1] = '{1'b0, 1'b1, 32'h0000_0010, 32'h0,         4'h0, 0, 0, 3, 0, 2'b00, 32'hDEADBEEF, 6, 1'b0, 32'hDEADBEEF};
        vecs[2] = '{1'b1, 1'b0, 32'h0000_0020, 32'hA5A5_0001, 4'h3, 2, 0, 0, 0, 2'b00, 32'h0,         5, 1'b0, 32'hDEADBEEF};
        vecs[3] = '{1'b1, 1'b0, 32'h0000_0024, 32'h1234_5678, 4'h0, 0, 2, 0, 1, 2'b00, 32'h0,         6, 1'b0, 32'hDEADBEEF};
        vecs[4] = '{1'b1, 1'b0, 32'h0000_0031, 32'hCAFE_F00D, 4'h8, 0, 0, 0, 0, 2'b10, 32'h0,         3, 1'b1, 32'hDEADBEEF};
        vecs[5] = '{1'b0, 1'b1, 32'h0000_0033, 32'h0,         4'h0, 0, 0, 0, 2, 2'b00, 32'h0BAD_F00D, 5, 1'b0, 32'h0BAD_F00D};
        vecs[6] = '{1'b0, 1'b1, 32'h0000_0040, 32'h0,         4'h0, 0, 0, 1, 0, 2'b11, 32'h1111_2222, 4, 1'b1, 32'h1111_2222};
        vecs[7] = '{1'b1, 1'b1, 32'h0000_0050, 32'h0000_0077, 4'hF, 0, 0, 0, 0, 2'b01, 32'h3333_4444, 3, 1'b1, 32'h1111_2222};

        cyc = 0; aw_count = 0; ar_count = 0; ready_pulses = 0; proto_errs = 0;
        cfg_aw_dly = 0; cfg_w_dly = 0; cfg_ar_dly = 0; cfg_rsp_dly = 0;
        cfg_resp = 2'b00; cfg_rdata = 32'h0;
        rst = 1'b1; req_read = 1'b0; req_write = 1'b0;
        req_addr = 32'hFFFF_FFFF; req_wdata = 32'hFFFF_FFFF; req_byte_enable = 4'hF;
        repeat (3) @(posedge clk);
        #1;
        check("reset channel controls",
              64'({m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_arvalid, m_axi_rready}), 64'd0);
        check("reset req_ready/req_error", 64'({req_ready, req_error}), 64'd0);
        check("reset req_rdata", 64'(req_rdata), 64'd0);
        check("reset addr regs", 64'({m_axi_awaddr, m_axi_araddr}), 64'd0);
        check("reset wdata/wstrb", 64'({m_axi_wdata, m_axi_wstrb}), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 8; i++) begin
            run_txn($sformatf("vec%0d", i), vecs[i].wr, vecs[i].rd, vecs[i].addr, vecs[i].wdata,
                    vecs[i].be, vecs[i].aw_dly, vecs[i].w_dly, vecs[i].ar_dly, vecs[i].rsp_dly,
                    vecs[i].resp, vecs[i].rdata, vecs[i].exp_lat, vecs[i].exp_err, vecs[i].exp_rdata);
        end

        // Reset while waiting for the write response.
        @(negedge clk);
        cfg_aw_dly = 0; cfg_w_dly = 0; cfg_rsp_dly = 50; cfg_resp = 2'b00;
        req_addr = 32'h0000_0060; req_wdata = 32'h5555_AAAA; req_byte_enable = 4'hF; req_write = 1'b1;
        seen = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            @(posedge clk); #1;
            if (m_axi_bready) begin
                seen = 1'b1;
                break;
            end
        end
        check("rst: reached write response wait", 64'(seen), 64'd1);
        @(negedge clk);
        rst = 1'b1;
        pulses0 = ready_pulses;
        @(posedge clk); #1;
        check("rst: channels idle",
              64'({m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_arvalid, m_axi_rready, req_ready}), 64'd0);
        @(negedge clk);
        rst = 1'b0; req_write = 1'b0;
        repeat (60) @(posedge clk);
        #1;
        check("rst: no ready pulse", 64'(ready_pulses - pulses0), 64'd0);
        check("rst: rdata cleared", 64'(req_rdata), 64'd0);
        run_txn("post-rst read", 1'b0, 1'b1, 32'h0000_0064, 32'h0, 4'h0, 0, 0, 0, 0,
                2'b00, 32'h600D_CAFE, 3, 1'b0, 32'h600D_CAFE);
        model_rdata = 32'h600D_CAFE;

`ifdef AXI_MASTER_TIMEOUT_EN
        mon_en = 1'b0;
        @(negedge clk);
        cfg_ar_dly = 32'hFFFF_FFFF; cfg_rsp_dly = 0;
        req_addr = 32'h0000_0070; req_read = 1'b1;
        exp_lat = 0;
        for (int c = 1; c <= 100; c++) begin
            @(posedge clk); #1;
            if (req_ready) begin
                exp_lat = c;
                break;
            end
        end
        check("watchdog latency", 64'(exp_lat), 64'd17);
        check("watchdog req_error", 64'(req_error), 64'd1);
        check("watchdog req_rdata", 64'(req_rdata), 64'hDEADBEEF);
        req_read = 1'b0;
        @(posedge clk); #1;
        check("watchdog channels idle",
              64'({m_axi_arvalid, m_axi_rready, req_ready}), 64'd0);
        cfg_ar_dly = 0;
        model_rdata = 32'hDEADBEEF;
        mon_en = 1'b1;
`endif

        for (int i = 0; i < 40; i++) begin
            wr    = 1'($urandom_range(0, 1));
            rd    = wr ? 1'($urandom_range(0, 1)) : 1'b1;
            addr  = $urandom;
            wdata = $urandom;
            be    = 4'($urandom_range(0, 15));
            awd   = $urandom_range(0, 3);
            wd    = $urandom_range(0, 3);
            ard   = $urandom_range(0, 3);
            rspd  = $urandom_range(0, 3);
            resp  = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            rdata = $urandom;
            exp_err = (resp != 2'b00);
            if (wr) begin
                exp_lat = 3 + ((awd > wd) ? awd : wd) + rspd;
            end else begin
                exp_lat = 3 + ard + rspd;
                model_rdata = rdata;
            end
            run_txn($sformatf("rnd%0d", i), wr, rd, addr, wdata, be, awd, wd, ard, rspd,
                    resp, rdata, exp_lat, exp_err, model_rdata);
        end

        check("protocol rules", 64'(proto_errs), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/axi_lite_master_bridge.md
Name: axi_lite_master_bridge

Overview:
- AXI4-Lite initiator: converts a CPU-side single-outstanding memory request (dmem-style addr/wdata/read/write/byte_enable/ready) into AXI4-Lite master transactions.
- Lets the core, or a debug/DMA agent, reach AXI4-Lite peripherals such as the CPU control register block on the PS/PL interconnect.
- One transaction in flight at a time; completion is reported back with read data and an error flag.

Parameters:
- ADDR_WIDTH, 32, request and AXI address width.
- DATA_WIDTH, 32, request and AXI data width; the strobe width is DATA_WIDTH/8.
- TIMEOUT_CYCLES, 1024, watchdog limit in cycles; used only when AXI_MASTER_TIMEOUT_EN is defined.

Ports:
- clk  input  1  single clock for the whole block.
- rst  input  1  synchronous, active-high reset.
- req_addr  input  ADDR_WIDTH  request byte address.
- req_wdata  input  DATA_WIDTH  write data.
- req_byte_enable  input  DATA_WIDTH/8  write byte lanes.
- req_read  input  1  read request; held until req_ready.
- req_write  input  1  write request; held until req_ready.
- req_rdata  output  DATA_WIDTH  read data of the last completed read.
- req_ready  output  1  one-cycle completion pulse.
- req_error  output  1  response was not OKAY, or the watchdog fired.
- m_axi_awaddr/awprot/awvalid  output  ADDR_WIDTH/3/1  write address channel.
- m_axi_awready  input  1.
- m_axi_wdata/wstrb/wvalid  output  DATA_WIDTH/DATA_WIDTH/8/1  write data channel.
- m_axi_wready  input  1.
- m_axi_bresp/bvalid  input  2/1  write response.
- m_axi_bready  output  1.
- m_axi_araddr/arprot/arvalid  output  ADDR_WIDTH/3/1  read address channel.
- m_axi_arready  input  1.
- m_axi_rdata/rresp/rvalid  input  DATA_WIDTH/2/1  read data.
- m_axi_rready  output  1.

Behaviour:
- Reset (synchronous, rst=1):
  - state = IDLE.
  - All m_axi valid and ready outputs = 0.
  - req_ready = 0, req_error = 0, req_rdata = 0.
  - Address, data and strobe output registers = 0.
  - Asserting rst mid-transaction aborts it: all valids drop on the next edge and no req_ready is issued.
- States: IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, DONE.
- IDLE:
  - If req_write=1, capture addr/wdata/byte_enable, clear req_error, go to WR_REQ.
  - Else if req_read=1, capture addr, clear req_error, go to RD_REQ.
  - If both are asserted, the write wins and the read is ignored.
- WR_REQ:
  - awvalid and wvalid are both asserted from the first WR_REQ cycle.
  - Each valid deasserts independently on its own handshake (awvalid&&awready, wvalid&&wready). Two internal "accepted" flags track this; either order, or the same cycle, is legal.
  - Go to WR_RESP in the cycle both flags are set, counting handshakes occurring in the current cycle.
  - Valids never deassert before their handshake.
- WR_RESP:
  - bready = 1.
  - On bvalid: req_error <= (bresp != 2'b00); go to DONE.
- RD_REQ:
  - arvalid = 1 until arready; then go to RD_RESP.
- RD_RESP:
  - rready = 1.
  - On rvalid: req_rdata <= rdata; req_error <= (rresp != 2'b00); go to DONE.
- DONE:
  - req_ready = 1 for exactly one cycle, then return to IDLE.
  - A request still asserted in the IDLE cycle that follows is treated as a new request. The requester must drop its request on seeing req_ready.
- Output field values:
  - awprot = arprot = 3'b000.
  - wstrb = captured byte_enable. Strobe 4'b0000 is passed through unchanged.
  - araddr and awaddr = captured req_addr, unmodified with no alignment.
- Hold rules:
  - req_rdata and req_error hold until the next completion.
  - A write does not modify req_rdata.
- Minimum latency, with slaves always ready and a response in the next cycle:
  - Request sampled in IDLE at cycle 0.
  - Address/data handshakes at cycle 1.
  - Response at cycle 2.
  - req_ready at cycle 3.
  - Back-to-back requests have a 4-cycle period.
- Request inputs are sampled only in IDLE; changes in other states are ignored.

Optional Feature:
- Macro: AXI_MASTER_TIMEOUT_EN.
- When defined:
  - A 32-bit wait counter clears on leaving IDLE and increments each cycle in WR_REQ, WR_RESP, RD_REQ and RD_RESP.
  - When the count reaches TIMEOUT_CYCLES, force all valids and readys to 0 and go to DONE.
  - Set req_error = 1; for reads, set req_rdata = 32'hDEADBEEF.
  - This is a debug watchdog and knowingly violates the AXI valid-hold rule.
- When not defined:
  - No counter exists.
  - The FSM waits indefinitely in any state.

Test Plan:
- Write, slaves always ready, bresp=OKAY: req_write addr 0x0000000C, wdata 0x00001000, be 4'hF -> awaddr=0xC, wdata=0x1000, wstrb=F handshake at cycle 1; req_ready pulses at cycle 3; req_error=0.
- Read with arready delayed 3 cycles, rdata 0xDEADBEEF, rresp=OKAY -> arvalid held for 4 cycles; req_rdata=0xDEADBEEF when req_ready pulses; exactly one req_ready pulse.
- Write with wready 2 cycles before awready, and the reverse order -> each valid drops after its own handshake; bready only after both handshakes; completion correct in both orders.
- bresp=2'b10 (SLVERR) on a write, then a read with OKAY -> req_error=1 on the first req_ready, 0 on the second.
- rst asserted while in WR_RESP -> next cycle all valids/readys 0, req_ready never pulses; a following read completes normally.
- With AXI_MASTER_TIMEOUT_EN and TIMEOUT_CYCLES=16, read with arready tied low -> req_ready at about cycle 17; req_error=1; req_rdata=0xDEADBEEF.
